// File: rtl/note_sequencer_pkg.sv
// Shared types and constants for the melody note sequencer: FSM state,
// tone-clkgen pitch values, note durations in fs samples, and the default tune.
package note_sequencer_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        PLAY = 2'd2,
        DONE = 2'd3
    } seq_state_t;

    localparam int PKG_PITCH_W   = 9;
    localparam int PKG_DUR_W     = 13;
    localparam int PKG_NUM_NOTES = 20;
    localparam int PKG_ENTRY_W   = PKG_PITCH_W + PKG_DUR_W;

    // Tone-clkgen maxval per note; 0 means rest
    localparam logic [PKG_PITCH_W-1:0] P_A     = 9'd177;
    localparam logic [PKG_PITCH_W-1:0] P_DHIGH = 9'd133;
    localparam logic [PKG_PITCH_W-1:0] P_C     = 9'd149;
    localparam logic [PKG_PITCH_W-1:0] P_B     = 9'd158;
    localparam logic [PKG_PITCH_W-1:0] P_G     = 9'd199;
    localparam logic [PKG_PITCH_W-1:0] P_FIS   = 9'd211;
    localparam logic [PKG_PITCH_W-1:0] P_E     = 9'd237;
    localparam logic [PKG_PITCH_W-1:0] P_D     = 9'd266;

    // Note lengths in 8 kHz samples; 0 marks end of melody
    localparam logic [PKG_DUR_W-1:0] D_EIGHTH        = 13'd2000;
    localparam logic [PKG_DUR_W-1:0] D_QUARTER       = 13'd4000;
    localparam logic [PKG_DUR_W-1:0] D_DOTTED_QUARTER = 13'd6000;
    localparam logic [PKG_DUR_W-1:0] D_HALF          = 13'd8000;

    function automatic logic [PKG_ENTRY_W-1:0] mk_note(input logic [PKG_PITCH_W-1:0] pitch,
                                                       input logic [PKG_DUR_W-1:0] dur);
        return {pitch, dur};
    endfunction

    // Entry i occupies bits [i*22 +: 22] as {pitch, duration}; listed from entry 19 down to 0
    localparam logic [PKG_NUM_NOTES*PKG_ENTRY_W-1:0] DEFAULT_MELODY = {
        mk_note(P_G,     D_HALF),
        mk_note(P_E,     D_EIGHTH),
        mk_note(P_FIS,   D_EIGHTH),
        mk_note(P_G,     D_QUARTER),
        mk_note(P_A,     D_QUARTER),
        mk_note(P_B,     D_EIGHTH),
        mk_note(P_C,     D_EIGHTH),
        mk_note(P_DHIGH, D_QUARTER),
        mk_note(P_D,     D_HALF),
        mk_note(P_E,     D_QUARTER),
        mk_note(P_FIS,   D_QUARTER),
        mk_note(P_G,     D_QUARTER),
        mk_note(P_A,     D_QUARTER),
        mk_note(P_B,     D_QUARTER),
        mk_note(P_C,     D_EIGHTH),
        mk_note(P_B,     D_DOTTED_QUARTER),
        mk_note(P_A,     D_EIGHTH),
        mk_note(P_G,     D_EIGHTH),
        mk_note(P_G,     D_QUARTER),
        mk_note(P_D,     D_QUARTER)
    };

endpackage

// File: rtl/note_sequencer_melody_rom.sv
// Constant melody table lookup: note index in, {pitch, duration} out.
module melody_rom
    import note_sequencer_pkg::*;
#(
    parameter int PITCH_BITWIDTH = 9,
    parameter int DUR_BITWIDTH   = 13,
    parameter int IDX_BITWIDTH   = 5,
    parameter int NUM_NOTES      = 20,
    parameter logic [NUM_NOTES*(PITCH_BITWIDTH+DUR_BITWIDTH)-1:0] MELODY = DEFAULT_MELODY
) (
    input  logic [IDX_BITWIDTH-1:0]   i_idx,
    output logic [PITCH_BITWIDTH-1:0] o_pitch,
    output logic [DUR_BITWIDTH-1:0]   o_dur
);

    localparam int ENTRY_W = PITCH_BITWIDTH + DUR_BITWIDTH;
    localparam logic [IDX_BITWIDTH-1:0] LAST_IDX = IDX_BITWIDTH'(NUM_NOTES - 1);

    // Indices past the table read as an end marker so playback cannot run off the end
    always_comb begin
        o_pitch = '0;
        o_dur   = '0;
        if (i_idx <= LAST_IDX) begin
            {o_pitch, o_dur} = MELODY[int'(i_idx)*ENTRY_W +: ENTRY_W];
        end
    end

endmodule

// File: rtl/note_sequencer.sv
// Melody sequencer: walks the note table, drives the downstream tone clkgen's
// maxval, and gates the tone with a short articulation gap at each note end.
module note_sequencer
    import note_sequencer_pkg::*;
#(
    parameter int PITCH_BITWIDTH = 9,
    parameter int DUR_BITWIDTH   = 13,
    parameter int IDX_BITWIDTH   = 5,
    parameter int NUM_NOTES      = 20,
    parameter int GAP_SAMPLES    = 200,
    parameter logic [NUM_NOTES*(PITCH_BITWIDTH+DUR_BITWIDTH)-1:0] MELODY = DEFAULT_MELODY
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      fs_tick,
    input  logic                      start,
    input  logic                      stop,
    input  logic                      loop_en,
    output logic [PITCH_BITWIDTH-1:0] pitch_o,
    output logic                      note_on,
    output logic                      note_strobe,
    output logic                      busy,
    output logic                      done,
    output logic [IDX_BITWIDTH-1:0]   note_idx
);

    localparam logic [IDX_BITWIDTH-1:0] LAST_IDX = IDX_BITWIDTH'(NUM_NOTES - 1);
    localparam logic [DUR_BITWIDTH-1:0] GAP      = DUR_BITWIDTH'(GAP_SAMPLES);
    localparam logic [DUR_BITWIDTH-1:0] GAP2     = DUR_BITWIDTH'(2 * GAP_SAMPLES);

    seq_state_t                r_state;
    seq_state_t                w_state_nx;
    logic [IDX_BITWIDTH-1:0]   r_idx;
    logic [IDX_BITWIDTH-1:0]   w_idx_nx;
    logic [PITCH_BITWIDTH-1:0] r_pitch;
    logic [DUR_BITWIDTH-1:0]   r_dur;
    logic [DUR_BITWIDTH-1:0]   r_cnt;
    logic                      r_strobe;
    logic                      w_load;
    logic                      w_cnt_inc;
    logic [PITCH_BITWIDTH-1:0] w_rom_pitch;
    logic [DUR_BITWIDTH-1:0]   w_rom_dur;
    logic [DUR_BITWIDTH-1:0]   w_on_limit;

    melody_rom #(
        .PITCH_BITWIDTH (PITCH_BITWIDTH),
        .DUR_BITWIDTH   (DUR_BITWIDTH),
        .IDX_BITWIDTH   (IDX_BITWIDTH),
        .NUM_NOTES      (NUM_NOTES),
        .MELODY         (MELODY)
    ) u_rom (
        .i_idx   (r_idx),
        .o_pitch (w_rom_pitch),
        .o_dur   (w_rom_dur)
    );

    // Short notes get no gap so they are not swallowed entirely by silence
    assign w_on_limit = (r_dur > GAP2) ? (r_dur - GAP) : r_dur;

    // FSM state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    // Next state, index/counter controls and outputs; stop overrides all non-IDLE activity
    always_comb begin
        w_state_nx  = r_state;
        w_idx_nx    = r_idx;
        w_load      = 1'b0;
        w_cnt_inc   = 1'b0;
        busy        = (r_state != IDLE);
        done        = (r_state == DONE);
        note_on     = (r_state == PLAY) && (r_pitch != '0) && (r_cnt < w_on_limit);
        note_strobe = r_strobe;
        pitch_o     = r_pitch;
        note_idx    = r_idx;

        case (r_state)
            IDLE: begin
                if (start && !stop) begin
                    w_state_nx = LOAD;
                    w_idx_nx   = '0;
                end
            end
            LOAD: begin
                if (w_rom_dur == '0) begin
                    // End marker; a marker at entry 0 always finishes to avoid a silent spin
                    if (loop_en && (r_idx != '0)) begin
                        w_idx_nx   = '0;
                        w_state_nx = LOAD;
                    end else begin
                        w_state_nx = DONE;
                    end
                end else begin
                    w_load     = 1'b1;
                    w_state_nx = PLAY;
                end
            end
            PLAY: begin
                if (fs_tick) begin
                    if (r_cnt == (r_dur - 1'b1)) begin
                        if (r_idx < LAST_IDX) begin
                            w_idx_nx   = r_idx + 1'b1;
                            w_state_nx = LOAD;
                        end else if (loop_en) begin
                            w_idx_nx   = '0;
                            w_state_nx = LOAD;
                        end else begin
                            w_state_nx = DONE;
                        end
                    end else begin
                        w_cnt_inc = 1'b1;
                    end
                end
            end
            DONE: begin
                w_state_nx = IDLE;
            end
            default: begin
                w_state_nx = IDLE;
            end
        endcase

        if (stop && (r_state != IDLE)) begin
            w_state_nx = IDLE;
            w_idx_nx   = r_idx;
            w_load     = 1'b0;
            w_cnt_inc  = 1'b0;
        end
    end

    // Note index, current note registers, sample counter and load strobe
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_idx    <= '0;
            r_pitch  <= '0;
            r_dur    <= '0;
            r_cnt    <= '0;
            r_strobe <= 1'b0;
        end else begin
            r_idx    <= w_idx_nx;
            r_strobe <= w_load;
            if (w_load) begin
                r_pitch <= w_rom_pitch;
                r_dur   <= w_rom_dur;
                r_cnt   <= '0;
            end else if (w_cnt_inc) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

endmodule

// File: doc/note_sequencer.md
NOTE_SEQUENCER -- requirements
Module: note_sequencer

Interface
REQ-001 Parameter PITCH_BITWIDTH, default 9, is the width of the tone-clkgen maxval.
REQ-002 Parameter DUR_BITWIDTH, default 13, is the width of the note-duration sample count.
REQ-003 Parameter IDX_BITWIDTH, default 5, is the width of the note index.
REQ-004 Parameter NUM_NOTES, default 20, is the number of melody table entries.
REQ-005 Parameter GAP_SAMPLES, default 200, is the articulation gap in fs samples at the end of each note.
REQ-006 Port clk, input, 1, is the single 10 MHz system clock.
REQ-007 Port reset, input, 1, is the reset: asynchronous, active-high.
REQ-008 Port fs_tick, input, 1, is a one-clk pulse at the sample rate (8 kHz).
REQ-009 Ports start and stop, inputs, 1 each, are level-sampled commands.
REQ-010 Port loop_en, input, 1, selects restart at melody end.
REQ-011 Port pitch_o, output, PITCH_BITWIDTH, is the maxval for the downstream tone clkgen.
REQ-012 Port note_on, output, 1, is high while a tone is sounding.
REQ-013 Port note_strobe, output, 1, is a one-clk pulse when a new note is loaded; it resets the downstream clkgen.
REQ-014 Port busy, output, 1, is high in every state except IDLE.
REQ-015 Port done, output, 1, is a one-clk pulse at natural melody end.
REQ-016 Port note_idx, output, IDX_BITWIDTH, is the current table index.

Function
REQ-017 FSM states SHALL be IDLE, LOAD, PLAY and DONE.
REQ-018 The melody table SHALL be a constant ROM of NUM_NOTES {pitch, duration} pairs; pitch 0 = rest, duration 0 = end marker.
REQ-019 IDLE: start=1 -> LOAD with note_idx=0; start sampled at cycle n gives LOAD at n+1, and pitch_o valid plus note_strobe at n+2.
REQ-020 LOAD (one clk) SHALL register pitch/duration of table[note_idx], clear the sample counter, pulse note_strobe, and go to PLAY.
REQ-021 LOAD on an entry with duration 0 SHALL be treated as melody end (REQ-024), with no note_strobe.
REQ-022 PLAY: the sample counter SHALL increment only on fs_tick; fs_tick is ignored in all other states.
REQ-023 PLAY: note_on = (pitch!=0) AND (counter < duration-GAP_SAMPLES); if duration <= 2*GAP_SAMPLES the gap is 0.
REQ-024 PLAY on fs_tick with counter == duration-1:
- note_idx < NUM_NOTES-1 -> note_idx+1, go to LOAD;
- otherwise loop_en=1 -> note_idx=0, go to LOAD;
- otherwise -> DONE.
REQ-025 DONE (one clk) SHALL pulse done, force note_on=0, and return to IDLE.
REQ-026 stop=1 in any non-IDLE state SHALL go to IDLE on the next clk with note_on=0, without a done pulse.
REQ-027 start and stop in the same cycle: stop wins; start while busy is ignored.
REQ-028 loop_en SHALL be sampled only at the last-sample decision of REQ-024.
REQ-029 Counter arithmetic SHALL be DUR_BITWIDTH unsigned with no overflow (counter < duration always); note_idx wraps only via REQ-024.
REQ-030 pitch_o SHALL hold its value through rest, DONE and IDLE until the next LOAD.

Reset
REQ-031 Reset SHALL asynchronously force: state=IDLE, pitch_o=0, note_on=0, note_strobe=0, busy=0, done=0, note_idx=0, counter=0.
REQ-032 Reset asserted mid-note SHALL abort immediately, with no done pulse; after release the block waits for a new start.

Structure
REQ-033 A shared package SHALL hold the FSM state enum, the pitch constants (A=177, Dhigh=133, C=149, B=158, G=199, Fis=211, E=237, D=266), the duration constants (eighth=2000, quarter=4000, dotted quarter=6000, half=8000), and the default 20-entry melody table.
REQ-034 There SHALL be one sub-module, melody_rom (index in -> {pitch, duration} out, combinational), instantiated once.

Verification
REQ-035 Reset, then start pulse at cycle n -> note_strobe at n+2, pitch_o=266, note_idx=0, note_on=1.
REQ-036 First note (duration 4000), fs_tick every 1250 clk -> note_on falls after tick 3800, LOAD after tick 4000, pitch_o=199, note_idx=1.
REQ-037 loop_en=0, play all 20 notes -> one done pulse after the final tick of entry 19, then busy=0 and note_idx=19; with loop_en=1 -> note_idx=0, pitch_o=266, no done.
REQ-038 stop at tick 1000 of note 3 -> next clk busy=0, note_on=0, no done; a later start restarts at note_idx=0.
REQ-039 Table with a rest (pitch 0, duration 2000) at entry 2 and a 0-duration end marker at entry 5 -> note_on=0 for 2000 ticks, then done after entry 4.
REQ-040 Async reset asserted mid-PLAY between clk edges -> all outputs 0 before the next edge; start and stop together in IDLE -> remains IDLE.
